uart_echo_tester: RTL and testbench
===================================

# uart_echo_tester

Host-side initiator for the UART echo path: it drives a configurable byte sequence onto the serial line that feeds the echo design's receive input. It then receives the echoed bytes on the return line and compares each against the byte it sent. Used on the bench and in on-board self-test as the far end of the 8N1 link. It reports the error count, timeout and pass/fail per run.

## Interface
Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); minimum 4
- TIMEOUT_CLKS, 20*868, cycles allowed from end of own stop bit to echo stop-bit completion

Ports:
- clk  in  1  system clock, single clock domain
- rst_n  in  1  asynchronous active-low reset
- start  in  1  run request; sampled only in IDLE
- seed  in  8  first byte of the sequence
- count  in  8  bytes per run; 0 = empty run
- txd  out  1  serial out, idle high, to echo design's receive input
- rxd  in  1  serial in from echo design's transmit output; asynchronous
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- pass  out  1  run result; held until next accepted start
- err_count  out  8  mismatched, framing-error or unexpected bytes; saturates at 255
- timeout  out  1  run aborted on missing echo; held until next accepted start

## Operation
- FSM states: IDLE, SEND, WAIT_ECHO, CHECK, DONE.
- IDLE:
  - start=1 latches seed and count, clears pass, timeout and err_count.
  - Goes to SEND, or to DONE if count=0.
- SEND: shifts one 10-bit frame: start 0, data LSB first, stop 1. After the stop bit, goes to WAIT_ECHO and loads the timeout counter.
- WAIT_ECHO:
  - A completed received byte goes to CHECK.
  - Timeout counter reaching 0 sets timeout=1 and goes to DONE.
- CHECK: compares the received byte with the sent byte; a mismatch increments err_count.
  - If bytes remain, advances the sequence and goes to SEND.
  - Otherwise goes to DONE.
- DONE: done=1 for one cycle, pass = (err_count==0 && !timeout); then IDLE.
- Sequence: byte i = seed + i mod 256 (wraps 0xFF→0x00).
- Receiver runs continuously, independent of the FSM:
  - 2-FF synchronizer on rxd.
  - Falling edge starts a frame. Start bit re-sampled at CLKS_PER_BIT/2; if high, it is a glitch and is discarded.
  - Data bits sampled at mid-bit.
  - Stop bit sampled low = framing error: err_count+1, byte not compared. In WAIT_ECHO the FSM stays in WAIT_ECHO.
  - Byte completing while FSM is not in WAIT_ECHO = unexpected: err_count+1.
- start while busy is ignored.

## Timing
- Reset values: txd=1, busy=0, done=0, pass=0, err_count=0, timeout=0; FSM IDLE; receiver idle.
- Reset asserted mid-frame: txd returns high asynchronously and any partial frame is dropped.
- start sampled high at edge k: at edge k+1, busy=1 and txd=0 (start bit begins).
- Each bit lasts exactly CLKS_PER_BIT cycles; txd is registered (no glitches). Frame = 10*CLKS_PER_BIT cycles.
- Received byte is valid to the FSM 1 cycle after the stop-bit mid-sample; CHECK takes 1 cycle.
- Next SEND start bit begins the cycle after CHECK.
- busy falls in the same cycle done pulses; start is accepted again from the following cycle.
- count=0: done pulses 2 cycles after start, with pass=1.
- Timeout counter counts only in WAIT_ECHO and is reloaded on every SEND exit.

## Configuration
- UART_ECHO_LFSR_EN defined:
  - Sequence is an 8-bit Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifted once per byte.
  - Byte 0 = seed; seed 0x00 is replaced by 0x01.
- Undefined: incrementing sequence as above; no LFSR logic synthesized.

## Test plan
- Loopback txd→rxd, count=3, seed=0x41 → txd frames 0x41, 0x42, 0x43; done once; pass=1, err_count=0, timeout=0.
- Echo model flips bit 0 of the 2nd byte (0x42→0x43), count=3 → err_count=1, pass=0, timeout=0.
- rxd tied high, count=2 → after 1 frame + TIMEOUT_CLKS, timeout=1, done, pass=0; only one frame on txd.
- Echo model returns 0x41 with stop bit low, count=1 → err_count=1, FSM then times out, pass=0.
- Extra spurious byte 0x55 on rxd while IDLE → err_count=1.
- rst_n low mid-data-bit of first frame → txd=1 and busy=0 immediately. After release, start with seed=0xFE, count=3 → 0xFE, 0xFF, 0x00; pass=1.
- start re-pulsed during SEND → ignored; exactly count frames sent.

Source files
------------

// File: rtl/uart_echo_tester.sv
// 8N1 initiator: sends a byte sequence, checks each echoed byte, reports pass/fail per run.
// Define UART_ECHO_LFSR_EN for an LFSR byte sequence instead of the incrementing one.
module uart_echo_tester #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned TIMEOUT_CLKS = 20*868
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] seed,
   input  logic [7:0] count,
   output logic       txd,
   input  logic       rxd,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_count,
   output logic       timeout
);
   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT/2 - 1);

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
   typedef enum logic [2:0] {IDLE, SEND, WAIT_ECHO, CHECK, DONE} state_e;

   rx_state_e     rx_state_q;
   logic [2:0]    rx_sync_q;
   logic [CW-1:0] rx_cnt_q;
   logic [2:0]    rx_bit_q;
   logic [7:0]    rx_shift_q;
   logic [7:0]    rx_data_q;
   logic          rx_valid_q;
   logic          rx_ferr_q;

   state_e        state_q;
   logic [7:0]    cur_byte_q;
   logic [7:0]    remain_q;
   logic [8:0]    tx_shift_q;
   logic [3:0]    tx_bit_q;
   logic [CW-1:0] tx_cnt_q;
   logic [TW-1:0] tmo_cnt_q;

   logic [7:0]    first_byte_d;
   logic [7:0]    next_byte_d;
   logic [1:0]    err_inc_d;
   logic [8:0]    err_sum_d;
   logic [7:0]    err_next_d;

`ifdef UART_ECHO_LFSR_EN
   assign first_byte_d = (seed == 8'h00) ? 8'h01 : seed;
   assign next_byte_d  = {cur_byte_q[6:0],
                          cur_byte_q[7] ^ cur_byte_q[5] ^ cur_byte_q[4] ^ cur_byte_q[3]};
`else
   assign first_byte_d = seed;
   assign next_byte_d  = cur_byte_q + 8'd1;
`endif

   // Echo mismatch, framing error and unexpected byte may coincide; saturate at 255.
   assign err_inc_d  = 2'((state_q == CHECK) && (rx_data_q != cur_byte_q))
                     + 2'(rx_ferr_q || (rx_valid_q && (state_q != WAIT_ECHO)));
   assign err_sum_d  = {1'b0, err_count} + 9'(err_inc_d);
   assign err_next_d = err_sum_d[8] ? 8'hFF : err_sum_d[7:0];

   // Free-running 8N1 receiver; rx_valid_q/rx_ferr_q pulse the cycle after the stop sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state_q <= R_IDLE;
         rx_sync_q  <= 3'b111;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_ferr_q  <= 1'b0;
      end else begin
         rx_sync_q  <= {rx_sync_q[1:0], rxd};
         rx_valid_q <= 1'b0;
         rx_ferr_q  <= 1'b0;
         rx_cnt_q   <= rx_cnt_q + 1'b1;
         case (rx_state_q)
            R_IDLE: begin
               rx_cnt_q <= '0;
               if (rx_sync_q[2] && !rx_sync_q[1]) rx_state_q <= R_START;
            end
            R_START: if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_q   <= '0;
               rx_bit_q   <= '0;
               rx_state_q <= rx_sync_q[1] ? R_IDLE : R_DATA;
            end
            R_DATA: if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_q   <= '0;
               rx_shift_q <= {rx_sync_q[1], rx_shift_q[7:1]};
               rx_bit_q   <= rx_bit_q + 1'b1;
               if (rx_bit_q == 3'd7) rx_state_q <= R_STOP;
            end
            R_STOP: if (rx_cnt_q == BIT_LAST) begin
               rx_state_q <= R_IDLE;
               rx_data_q  <= rx_shift_q;
               rx_valid_q <= rx_sync_q[1];
               rx_ferr_q  <= !rx_sync_q[1];
            end
            default: rx_state_q <= R_IDLE;
         endcase
      end
   end

   // Run sequencer and transmitter; a start in the done cycle is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cur_byte_q <= '0;
         remain_q   <= '0;
         tx_shift_q <= '1;
         tx_bit_q   <= '0;
         tx_cnt_q   <= '0;
         tmo_cnt_q  <= '0;
         txd        <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         timeout    <= 1'b0;
      end else begin
         done      <= 1'b0;
         err_count <= err_next_d;
         case (state_q)
            IDLE: if (start && !done) begin
               cur_byte_q <= first_byte_d;
               remain_q   <= count;
               pass       <= 1'b0;
               timeout    <= 1'b0;
               err_count  <= '0;
               busy       <= 1'b1;
               if (count == 8'd0) begin
                  state_q <= DONE;
               end else begin
                  state_q    <= SEND;
                  txd        <= 1'b0;
                  tx_shift_q <= {1'b1, first_byte_d};
                  tx_bit_q   <= '0;
                  tx_cnt_q   <= '0;
               end
            end
            SEND: begin
               tx_cnt_q <= tx_cnt_q + 1'b1;
               if (tx_cnt_q == BIT_LAST) begin
                  tx_cnt_q <= '0;
                  if (tx_bit_q == 4'd9) begin
                     state_q   <= WAIT_ECHO;
                     tmo_cnt_q <= TW'(TIMEOUT_CLKS);
                  end else begin
                     txd        <= tx_shift_q[0];
                     tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                     tx_bit_q   <= tx_bit_q + 1'b1;
                  end
               end
            end
            WAIT_ECHO: begin
               if (rx_valid_q) begin
                  state_q <= CHECK;
               end else if (tmo_cnt_q == '0) begin
                  timeout <= 1'b1;
                  state_q <= DONE;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q - 1'b1;
               end
            end
            CHECK: begin
               if (remain_q > 8'd1) begin
                  remain_q   <= remain_q - 8'd1;
                  cur_byte_q <= next_byte_d;
                  tx_shift_q <= {1'b1, next_byte_d};
                  tx_bit_q   <= '0;
                  tx_cnt_q   <= '0;
                  txd        <= 1'b0;
                  state_q    <= SEND;
               end else begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               pass    <= (err_count == 8'd0) && !timeout;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_echo_tester.sv
// Bench for uart_echo_tester: txd monitor plus a behavioural echo partner on rxd.
module tb_uart_echo_tester;
   localparam int unsigned CPB = 8;
   localparam int unsigned TMO = 20*CPB;
   localparam int M_NONE = 0, M_LOOP = 1, M_FLIP = 2, M_BADSTOP = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start = 1'b0;
   logic [7:0] seed = '0;
   logic [7:0] count = '0;
   logic       rxd = 1'b1;
   logic       txd, busy, done, pass, timeout;
   logic [7:0] err_count;

   int n_cmp = 0;
   int n_bad = 0;
   int mode = M_NONE;
   int run_base = 0;
   int done_cnt = 0;
   int spur_req = 0;
   int echo_rd = 0;
   int spur_done = 0;
   logic [7:0] txq[$];
   logic [8:0] echoq[$];
   logic [7:0] mon_b;
   logic       mon_ok;
   int         mon_idx;

   uart_echo_tester #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .count(count),
      .txd(txd), .rxd(rxd), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .timeout(timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] seq_first(input logic [7:0] s);
`ifdef UART_ECHO_LFSR_EN
      return (s == 8'h00) ? 8'h01 : s;
`else
      return s;
`endif
   endfunction

   function automatic logic [7:0] seq_next(input logic [7:0] b);
`ifdef UART_ECHO_LFSR_EN
      int fb;
      fb = ((b >> 7) + (b >> 5) + (b >> 4) + (b >> 3)) % 2;
      return 8'(((b * 2) % 256) + fb);
`else
      return 8'((b + 1) % 256);
`endif
   endfunction

   // Decode every frame on txd; frames cut by reset are discarded.
   initial begin
      forever begin
         @(negedge txd);
         mon_ok = (rst_n === 1'b1);
         repeat (CPB/2) @(posedge clk);
         mon_ok = mon_ok && (txd === 1'b0) && (rst_n === 1'b1);
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            mon_b[i] = txd;
            mon_ok = mon_ok && (rst_n === 1'b1);
         end
         repeat (CPB) @(posedge clk);
         mon_ok = mon_ok && (txd === 1'b1) && (rst_n === 1'b1);
         if (mon_ok) begin
            mon_idx = txq.size() - run_base;
            txq.push_back(mon_b);
            case (mode)
               M_LOOP:    echoq.push_back({1'b1, mon_b});
               M_FLIP:    echoq.push_back({1'b1, (mon_idx == 1) ? (mon_b ^ 8'h01) : mon_b});
               M_BADSTOP: echoq.push_back({1'b0, mon_b});
               default: ;
            endcase
         end
      end
   end

   task automatic send_rx(input logic [7:0] b, input logic stop_bit);
      rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (CPB) @(negedge clk);
      end
      rxd = stop_bit;
      repeat (CPB) @(negedge clk);
      rxd = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   // Sole driver of rxd: echoes queued bytes and injects requested spurious bytes.
   initial begin
      forever begin
         @(negedge clk);
         if (echo_rd < echoq.size()) begin
            send_rx(echoq[echo_rd][7:0], echoq[echo_rd][8]);
            echo_rd++;
         end else if (spur_done < spur_req) begin
            send_rx(8'h55, 1'b1);
            spur_done++;
         end
      end
   end

   task automatic run(input logic [7:0] s, input logic [7:0] c, input int m, input bit repulse);
      logic [7:0] exp_b[$];
      logic [7:0] b;
      int n_exp, exp_err, base, dbase, cyc, budget, n_got;
      bit exp_tmo, exp_pass, got;
      n_exp = (c == 0) ? 0 : ((m == M_NONE || m == M_BADSTOP) ? 1 : int'(c));
      b = seq_first(s);
      for (int i = 0; i < n_exp; i++) begin
         exp_b.push_back(b);
         b = seq_next(b);
      end
      exp_err  = ((m == M_BADSTOP && c != 0) || (m == M_FLIP && c >= 2)) ? 1 : 0;
      exp_tmo  = (c != 0) && (m == M_NONE || m == M_BADSTOP);
      exp_pass = (exp_err == 0) && !exp_tmo;

      mode = m;
      base = txq.size();
      run_base = base;
      dbase = done_cnt;
      @(negedge clk);
      seed = s; count = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1);
      if (c != 0) check("start_bit", txd, 0);
      check("pass_cleared", pass, 0);

      budget = int'(c) * 30 * CPB + TMO + 100;
      cyc = 0; got = 0;
      while (!got && cyc < budget) begin
         @(negedge clk);
         cyc++;
         start = (repulse && cyc == 3*CPB) ? 1'b1 : 1'b0;
         if (done === 1'b1) got = 1;
      end
      start = 1'b0;
      check("done_seen", got, 1);
      if (c == 0) check("empty_done_latency", cyc, 1);
      if (m == M_NONE && c != 0)
         check("timeout_latency", (cyc >= 10*CPB + TMO) && (cyc <= 10*CPB + TMO + 4), 1);
      check("busy_at_done", busy, 0);
      check("pass", pass, exp_pass);
      check("timeout", timeout, exp_tmo);
      check("err_count", err_count, exp_err);

      repeat (14*CPB) @(negedge clk);
      n_got = txq.size() - base;
      check("frame_count", n_got, n_exp);
      for (int i = 0; i < n_exp && i < n_got; i++) check("frame_byte", txq[base + i], exp_b[i]);
      check("done_pulses", done_cnt - dbase, 1);
      check("pass_held", pass, exp_pass);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_txd", txd, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_err", err_count, 0);
      check("rst_timeout", timeout, 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      run(8'h41, 8'd3, M_LOOP, 0);
      run(8'h41, 8'd3, M_FLIP, 0);
      run(8'h41, 8'd2, M_NONE, 0);
      run(8'h41, 8'd1, M_BADSTOP, 0);
      run(8'h10, 8'd0, M_LOOP, 0);
      run(8'h20, 8'd3, M_LOOP, 1);

      // Spurious byte while idle
      mode = M_NONE;
      spur_req++;
      repeat (16*CPB) @(negedge clk);
      check("spurious_err", err_count, 1);
      check("spurious_busy", busy, 0);

      // Reset in the middle of a data bit of the first frame
      mode = M_NONE;
      run_base = txq.size();
      @(negedge clk);
      seed = 8'h33; count = 8'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3*CPB + CPB/2) @(negedge clk);
      check("txd_mid_frame", txd, 0);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_txd", txd, 1);
      check("async_rst_busy", busy, 0);
      repeat (2*CPB) @(negedge clk);
      rst_n = 1'b1;
      check("post_rst_err", err_count, 0);
      repeat (12*CPB) @(negedge clk);
      run(8'hFE, 8'd3, M_LOOP, 0);

      for (int r = 0; r < 3; r++)
         run(8'($urandom_range(0, 255)), 8'($urandom_range(1, 4)), M_LOOP, 0);
      run(8'($urandom_range(0, 255)), 8'd3, M_FLIP, 0);
      run(8'($urandom_range(0, 255)), 8'd2, M_BADSTOP, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
